sha256_req_arbiter: RTL and testbench

- Shares one SHA256top single-block hash core between NUM_REQ requesters.
- Arbitrates requests round-robin and latches the winner's 512-bit block.
- Sequences the core's level-sensitive start/done handshake, including the mandatory release phase before the next job.
- Returns each digest with the requester ID under valid/ready flow control. A watchdog flags a hung core.

---
 rtl/sha256_req_arbiter.sv | 148 ++++++++++++++
 tb/tb_sha256_req_arbiter.sv | 347 ++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/sha256_req_arbiter.sv
// Round-robin front end that shares one single-block SHA-256 core between NUM_REQ requesters.
// Drives the core's level start/done handshake, buffers one digest and watches for a hung core.
module sha256_req_arbiter #(
  parameter int NUM_REQ     = 4,
  parameter int ID_W        = 2,
  parameter int TIMEOUT_CYC = 128
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic [NUM_REQ-1:0]     req,
  input  logic [NUM_REQ*512-1:0] blk_data,
  output logic [NUM_REQ-1:0]     ack,
  output logic                   res_valid,
  input  logic                   res_ready,
  output logic [255:0]           res_digest,
  output logic [ID_W-1:0]        res_id,
  output logic                   core_start,
  output logic [511:0]           core_block,
  input  logic                   core_done,
  input  logic [255:0]           core_result,
  output logic                   busy,
  output logic                   timeout_err,
  output logic [ID_W-1:0]        err_id,
  input  logic                   clr_err
);

  localparam int              WD_W     = $clog2(TIMEOUT_CYC) + 1;
  localparam logic [WD_W-1:0] WD_LIMIT = WD_W'(TIMEOUT_CYC - 1);
  localparam logic [ID_W-1:0] RR_INIT  = ID_W'(NUM_REQ - 1);

  typedef enum logic [1:0] {
    S_ARB = 2'd0,
    S_RUN = 2'd1,
    S_REL = 2'd2,
    S_OUT = 2'd3
  } state_t;

  state_t              state_r;
  logic [ID_W-1:0]     rr_r;
  logic [ID_W-1:0]     cur_id_r;
  logic [WD_W-1:0]     wd_r;
  logic                have_res_r;

  logic                found_s;
  logic [ID_W-1:0]     idx_s;
  logic [ID_W-1:0]     win_s;
  logic [NUM_REQ-1:0]  win_oh_s;
  logic [511:0]        win_blk_s;

  // Round-robin search from rr+1 upward with wrap, then select the winner's block
  always_comb begin
    found_s   = 1'b0;
    idx_s     = '0;
    win_s     = rr_r;
    win_oh_s  = '0;
    win_blk_s = '0;
    for (int k = 1; k <= NUM_REQ; k++) begin
      idx_s   = ID_W'((int'(rr_r) + k) % NUM_REQ);
      win_s   = (req[idx_s] && !found_s) ? idx_s : win_s;
      found_s = found_s | req[idx_s];
    end
    for (int i = 0; i < NUM_REQ; i++) begin
      win_oh_s[i] = (ID_W'(i) == win_s);
      win_blk_s   = win_oh_s[i] ? blk_data[i*512 +: 512] : win_blk_s;
    end
  end

  // Job sequencer: grant, run with watchdog, release handshake, hold result until accepted
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_r     <= S_ARB;
      rr_r        <= RR_INIT;
      cur_id_r    <= '0;
      wd_r        <= '0;
      have_res_r  <= 1'b0;
      ack         <= '0;
      core_start  <= 1'b0;
      core_block  <= '0;
      res_valid   <= 1'b0;
      res_digest  <= '0;
      res_id      <= '0;
      busy        <= 1'b0;
      timeout_err <= 1'b0;
      err_id      <= '0;
    end else begin
      ack <= '0;
      // A timeout raised below in the same cycle overrides this clear
      if (clr_err) timeout_err <= 1'b0;
      case (state_r)
        S_ARB: begin
          // A done still high from the previous job means the core has not returned to idle
          if (!core_done && found_s) begin
            core_block <= win_blk_s;
            ack        <= win_oh_s;
            core_start <= 1'b1;
            cur_id_r   <= win_s;
            rr_r       <= win_s;
            wd_r       <= '0;
            have_res_r <= 1'b0;
            busy       <= 1'b1;
            state_r    <= S_RUN;
          end
        end
        S_RUN: begin
          if (core_done) begin
            res_digest <= core_result;
            res_id     <= cur_id_r;
            have_res_r <= 1'b1;
            core_start <= 1'b0;
            state_r    <= S_REL;
          end else if (wd_r >= WD_LIMIT) begin
            timeout_err <= 1'b1;
            err_id      <= cur_id_r;
            core_start  <= 1'b0;
            state_r     <= S_REL;
          end else begin
            wd_r <= wd_r + WD_W'(1);
          end
        end
        S_REL: begin
          if (!core_done) begin
            if (have_res_r) begin
              res_valid <= 1'b1;
              state_r   <= S_OUT;
            end else begin
              busy    <= 1'b0;
              state_r <= S_ARB;
            end
          end
        end
        S_OUT: begin
          if (res_ready) begin
            res_valid <= 1'b0;
            busy      <= 1'b0;
            state_r   <= S_ARB;
          end
        end
        default: begin
          core_start <= 1'b0;
          res_valid  <= 1'b0;
          busy       <= 1'b0;
          state_r    <= S_ARB;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_sha256_req_arbiter.sv
// Bench for sha256_req_arbiter: behavioural SHA-256 core stand-in, ack-time scoreboard,
// round-robin vector table and hand sequences for backpressure, timeout and mid-job reset.
module tb_sha256_req_arbiter;

  localparam int NUM_REQ     = 4;
  localparam int ID_W        = 2;
  localparam int TIMEOUT_CYC = 128;
  localparam int CORE_LAT    = 68;

  localparam logic [255:0] ABC_DIGEST =
    256'hba7816bf8f01cfea414140de5dae2223b00361a396177a9cb410ff61f20015ad;
  localparam logic [511:0] ABC_BLK = {32'h61626380, 448'h0, 32'h00000018};

  localparam logic [31:0] K_TAB [64] = '{
    32'h428a2f98, 32'h71374491, 32'hb5c0fbcf, 32'he9b5dba5, 32'h3956c25b, 32'h59f111f1, 32'h923f82a4, 32'hab1c5ed5,
    32'hd807aa98, 32'h12835b01, 32'h243185be, 32'h550c7dc3, 32'h72be5d74, 32'h80deb1fe, 32'h9bdc06a7, 32'hc19bf174,
    32'he49b69c1, 32'hefbe4786, 32'h0fc19dc6, 32'h240ca1cc, 32'h2de92c6f, 32'h4a7484aa, 32'h5cb0a9dc, 32'h76f988da,
    32'h983e5152, 32'ha831c66d, 32'hb00327c8, 32'hbf597fc7, 32'hc6e00bf3, 32'hd5a79147, 32'h06ca6351, 32'h14292967,
    32'h27b70a85, 32'h2e1b2138, 32'h4d2c6dfc, 32'h53380d13, 32'h650a7354, 32'h766a0abb, 32'h81c2c92e, 32'h92722c85,
    32'ha2bfe8a1, 32'ha81a664b, 32'hc24b8b70, 32'hc76c51a3, 32'hd192e819, 32'hd6990624, 32'hf40e3585, 32'h106aa070,
    32'h19a4c116, 32'h1e376c08, 32'h2748774c, 32'h34b0bcb5, 32'h391c0cb3, 32'h4ed8aa4a, 32'h5b9cca4f, 32'h682e6ff3,
    32'h748f82ee, 32'h78a5636f, 32'h84c87814, 32'h8cc70208, 32'h90befffa, 32'ha4506ceb, 32'hbef9a3f7, 32'hc67178f2
  };
  localparam logic [31:0] H_INIT [8] = '{
    32'h6a09e667, 32'hbb67ae85, 32'h3c6ef372, 32'ha54ff53a, 32'h510e527f, 32'h9b05688c, 32'h1f83d9ab, 32'h5be0cd19
  };

  logic                   clk;
  logic                   reset;
  logic [NUM_REQ-1:0]     req;
  logic [NUM_REQ*512-1:0] blk_data;
  logic [NUM_REQ-1:0]     ack;
  logic                   res_valid;
  logic                   res_ready;
  logic [255:0]           res_digest;
  logic [ID_W-1:0]        res_id;
  logic                   core_start;
  logic [511:0]           core_block;
  logic                   core_done;
  logic [255:0]           core_result;
  logic                   busy;
  logic                   timeout_err;
  logic [ID_W-1:0]        err_id;
  logic                   clr_err;

  typedef struct {
    logic [ID_W-1:0] id;
    logic [255:0]    dig;
  } exp_t;

  typedef struct {
    logic [NUM_REQ-1:0] mask;
    int                 exp_id;
  } vec_t;

  int   n_tests;
  int   n_fail;
  bit   core_hang;
  int   ack_cnt [NUM_REQ];
  exp_t sb_q [$];
  exp_t mon_e;
  logic prev_start;
  logic prev_done;

  sha256_req_arbiter #(.NUM_REQ(NUM_REQ), .ID_W(ID_W), .TIMEOUT_CYC(TIMEOUT_CYC)) dut (
    .clk(clk), .reset(reset), .req(req), .blk_data(blk_data), .ack(ack),
    .res_valid(res_valid), .res_ready(res_ready), .res_digest(res_digest), .res_id(res_id),
    .core_start(core_start), .core_block(core_block), .core_done(core_done), .core_result(core_result),
    .busy(busy), .timeout_err(timeout_err), .err_id(err_id), .clr_err(clr_err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [31:0] ror(input logic [31:0] x, input int n);
    return (x >> n) | (x << (32 - n));
  endfunction

  function automatic logic [255:0] sha256_ref(input logic [511:0] blk);
    logic [31:0] w [64];
    logic [31:0] a, b, c, d, e, f, g, h, t1, t2;
    for (int i = 0; i < 16; i++) w[i] = blk[511-32*i -: 32];
    for (int i = 16; i < 64; i++)
      w[i] = w[i-16] + (ror(w[i-15], 7) ^ ror(w[i-15], 18) ^ (w[i-15] >> 3)) + w[i-7]
           + (ror(w[i-2], 17) ^ ror(w[i-2], 19) ^ (w[i-2] >> 10));
    a = H_INIT[0]; b = H_INIT[1]; c = H_INIT[2]; d = H_INIT[3];
    e = H_INIT[4]; f = H_INIT[5]; g = H_INIT[6]; h = H_INIT[7];
    for (int i = 0; i < 64; i++) begin
      t1 = h + (ror(e, 6) ^ ror(e, 11) ^ ror(e, 25)) + ((e & f) ^ (~e & g)) + K_TAB[i] + w[i];
      t2 = (ror(a, 2) ^ ror(a, 13) ^ ror(a, 22)) + ((a & b) ^ (a & c) ^ (b & c));
      h = g; g = f; f = e; e = d + t1; d = c; c = b; b = a; a = t1 + t2;
    end
    return {a + H_INIT[0], b + H_INIT[1], c + H_INIT[2], d + H_INIT[3],
            e + H_INIT[4], f + H_INIT[5], g + H_INIT[6], h + H_INIT[7]};
  endfunction

  task automatic chk(input string name, input logic [511:0] got, input logic [511:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h", name, got, exp);
    end
  endtask

  // Core stand-in: latches the block on start, raises done after CORE_LAT cycles, holds it until start drops
  logic [1:0]   cm_st;
  logic [7:0]   cm_cnt;
  logic [511:0] cm_blk;
  always @(posedge clk or negedge reset) begin
    if (!reset) begin
      cm_st <= 2'd0; cm_cnt <= 8'd0; cm_blk <= '0; core_done <= 1'b0; core_result <= '0;
    end else begin
      case (cm_st)
        2'd0: if (core_start) begin cm_blk <= core_block; cm_cnt <= 8'd0; cm_st <= 2'd1; end
        2'd1: begin
          if (!core_start) cm_st <= 2'd0;
          else if (!core_hang) begin
            if (int'(cm_cnt) == CORE_LAT - 1) begin
              core_done <= 1'b1; core_result <= sha256_ref(cm_blk); cm_st <= 2'd2;
            end else cm_cnt <= cm_cnt + 8'd1;
          end
        end
        default: if (!core_start) begin core_done <= 1'b0; cm_st <= 2'd0; end
      endcase
    end
  end

  // Monitor: ack-time scoreboard push, handshake rules, result pop/compare
  always @(negedge clk) begin
    if (!reset) begin
      prev_start = 1'b0;
      prev_done  = 1'b0;
      sb_q.delete();
    end else begin
      if (|ack) begin
        chk("ack_onehot", 512'($countones(ack)), 512'(1));
        chk("ack_with_start", 512'(core_start), 512'(1));
        for (int i = 0; i < NUM_REQ; i++) begin
          if (ack[i]) begin
            ack_cnt[i]++;
            chk("ack_block", core_block, blk_data[i*512 +: 512]);
            if (!core_hang) begin
              mon_e.id  = ID_W'(i);
              mon_e.dig = sha256_ref(blk_data[i*512 +: 512]);
              sb_q.push_back(mon_e);
            end
          end
        end
      end
      if (prev_done && prev_start) chk("start_release", 512'(core_start), 512'(0));
      if (!prev_start && core_start) chk("start_after_done_low", 512'(prev_done), 512'(0));
      if (res_valid && res_ready) begin
        chk("result_expected", 512'(sb_q.size() > 0), 512'(1));
        if (sb_q.size() > 0) begin
          mon_e = sb_q.pop_front();
          chk("res_id", 512'(res_id), 512'(mon_e.id));
          chk("res_digest", 512'(res_digest), 512'(mon_e.dig));
        end
      end
      prev_start = core_start;
      prev_done  = core_done;
    end
  end

  task automatic drive();
    @(posedge clk);
    #1;
  endtask

  task automatic wait_ack(output int id);
    bit seen;
    seen = 1'b0;
    id   = -1;
    for (int c = 0; c < 400 && !seen; c++) begin
      @(negedge clk);
      if (|ack) begin
        seen = 1'b1;
        for (int i = 0; i < NUM_REQ; i++) if (ack[i]) id = i;
      end
    end
    chk("ack_wait", 512'(seen), 512'(1));
  endtask

  task automatic wait_valid();
    bit seen;
    seen = 1'b0;
    for (int c = 0; c < 400 && !seen; c++) begin
      @(negedge clk);
      seen = res_valid;
    end
    chk("valid_wait", 512'(seen), 512'(1));
  endtask

  task automatic wait_idle();
    bit seen;
    seen = 1'b0;
    for (int c = 0; c < 400 && !seen; c++) begin
      @(negedge clk);
      seen = !busy;
    end
    chk("idle_wait", 512'(seen), 512'(1));
  endtask

  task automatic rand_block(input int r);
    for (int w = 0; w < 16; w++) blk_data[r*512 + w*32 +: 32] = $urandom();
  endtask

  initial begin
    #500000;
    $display("FAIL global_timeout: bench did not finish");
    $fatal(1, "global timeout");
  end

  initial begin
    vec_t vecs [12];
    int   got;
    int   base;
    int   bad;
    logic [255:0] hold_dig;

    // Expected grants assume rr = 0 on entry (left there by the first "abc" job)
    vecs[0]  = '{4'b1111, 1}; vecs[1]  = '{4'b1111, 2}; vecs[2]  = '{4'b1111, 3};
    vecs[3]  = '{4'b1111, 0}; vecs[4]  = '{4'b1111, 1}; vecs[5]  = '{4'b0110, 2};
    vecs[6]  = '{4'b1001, 3}; vecs[7]  = '{4'b1000, 3}; vecs[8]  = '{4'b0100, 2};
    vecs[9]  = '{4'b0011, 0}; vecs[10] = '{4'b0001, 0}; vecs[11] = '{4'b0010, 1};

    n_tests = 0; n_fail = 0; core_hang = 1'b0;
    for (int i = 0; i < NUM_REQ; i++) ack_cnt[i] = 0;
    reset = 1'b1; req = '0; blk_data = '0; res_ready = 1'b0; clr_err = 1'b0;
    #2 reset = 1'b0;
    repeat (3) @(negedge clk);
    chk("rst_ack", 512'(ack), 512'(0));
    chk("rst_res_valid", 512'(res_valid), 512'(0));
    chk("rst_res_digest", 512'(res_digest), 512'(0));
    chk("rst_res_id", 512'(res_id), 512'(0));
    chk("rst_core_start", 512'(core_start), 512'(0));
    chk("rst_core_block", core_block, 512'(0));
    chk("rst_busy", 512'(busy), 512'(0));
    chk("rst_timeout_err", 512'(timeout_err), 512'(0));
    chk("rst_err_id", 512'(err_id), 512'(0));
    drive(); reset = 1'b1;

    // Single "abc" job
    blk_data[511:0] = ABC_BLK; res_ready = 1'b1; base = ack_cnt[0];
    drive(); req = 4'b0001;
    wait_ack(got);
    chk("abc_grant", 512'(got), 512'(0));
    req = 4'b0000;
    wait_valid();
    chk("abc_digest", 512'(res_digest), 512'(ABC_DIGEST));
    chk("abc_id", 512'(res_id), 512'(0));
    wait_idle();
    chk("abc_ack_pulses", 512'(ack_cnt[0] - base), 512'(1));

    // Round-robin vector table
    for (int r = 0; r < NUM_REQ; r++) rand_block(r);
    for (int v = 0; v < 12; v++) begin
      req = vecs[v].mask;
      wait_ack(got);
      chk("rr_grant", 512'(got), 512'(vecs[v].exp_id));
      drive();
      if (got >= 0) rand_block(got);
    end
    req = '0;
    wait_idle();

    // Backpressure with requester 1 waiting behind an unaccepted result
    res_ready = 1'b0;
    drive(); req = 4'b0001;
    wait_ack(got);
    chk("bp_grant", 512'(got), 512'(0));
    req = 4'b0000;
    wait_valid();
    hold_dig = res_digest;
    drive(); req = 4'b0010;
    bad = 0;
    for (int c = 0; c < 50; c++) begin
      @(negedge clk);
      if (!res_valid || res_digest !== hold_dig || ack[1]) bad++;
    end
    chk("bp_hold_stable", 512'(bad), 512'(0));
    drive(); res_ready = 1'b1;
    @(negedge clk);
    @(negedge clk);
    chk("bp_no_ack_yet", 512'(ack), 512'(0));
    chk("bp_valid_dropped", 512'(res_valid), 512'(0));
    @(negedge clk);
    chk("bp_ack1_after_accept", 512'(ack), 512'(4'b0010));
    req = 4'b0000;
    wait_idle();

    // Watchdog: core never answers
    core_hang = 1'b1;
    drive(); req = 4'b0100;
    wait_ack(got);
    req = 4'b0000;
    chk("to_grant", 512'(got), 512'(2));
    repeat (TIMEOUT_CYC - 1) @(negedge clk);
    chk("to_not_yet", 512'(timeout_err), 512'(0));
    @(negedge clk);
    chk("to_flag", 512'(timeout_err), 512'(1));
    chk("to_err_id", 512'(err_id), 512'(2));
    chk("to_no_result", 512'(res_valid), 512'(0));
    wait_idle();
    chk("to_sticky", 512'(timeout_err), 512'(1));
    drive(); clr_err = 1'b1;
    drive(); clr_err = 1'b0;
    @(negedge clk);
    chk("to_cleared", 512'(timeout_err), 512'(0));
    core_hang = 1'b0;
    drive(); req = 4'b1000;
    wait_ack(got);
    req = 4'b0000;
    chk("after_to_grant", 512'(got), 512'(3));
    wait_valid();
    chk("after_to_id", 512'(res_id), 512'(3));
    wait_idle();

    // Asynchronous reset in the middle of a job
    blk_data[511:0] = ABC_BLK;
    drive(); req = 4'b0001;
    wait_ack(got);
    req = 4'b0000;
    repeat (30) @(negedge clk);
    #2 reset = 1'b0;
    #1;
    chk("mid_rst_core_start", 512'(core_start), 512'(0));
    chk("mid_rst_ack", 512'(ack), 512'(0));
    chk("mid_rst_res_valid", 512'(res_valid), 512'(0));
    chk("mid_rst_busy", 512'(busy), 512'(0));
    repeat (2) @(negedge clk);
    drive(); reset = 1'b1;
    drive(); req = 4'b0001;
    wait_ack(got);
    req = 4'b0000;
    chk("post_rst_grant", 512'(got), 512'(0));
    wait_valid();
    chk("post_rst_digest", 512'(res_digest), 512'(ABC_DIGEST));
    chk("post_rst_id", 512'(res_id), 512'(0));
    wait_idle();

    chk("sb_empty", 512'(sb_q.size()), 512'(0));
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
